// File: rtl/pm_sensor_sweep_ctrl.sv
// pm_sensor_sweep_ctrl: APB master that sweeps a range of PM sensors and streams each status result
module pm_sensor_sweep_ctrl #(
   parameter int SEL_W = 5,
   parameter int RUN_BIT = 10,
   parameter int POLL_GAP = 8,
   parameter int MAX_POLLS = 1024,
   parameter logic [4:0] ADDR_CTRL = 5'h04,
   parameter logic [4:0] ADDR_REF = 5'h08,
   parameter logic [4:0] ADDR_STAT = 5'h0C
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             start,
   input  logic             abort,
   input  logic [SEL_W-1:0] first_idx,
   input  logic [SEL_W-1:0] last_idx,
   input  logic [31:0]      ref_window,
   output logic             psel,
   output logic             penable,
   output logic             pwrite,
   output logic [4:0]       paddr,
   output logic [31:0]      pwdata,
   input  logic [31:0]      prdata,
   input  logic             pready,
   input  logic             pslverr,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SEL_W-1:0] res_idx,
   output logic [31:0]      res_data,
   output logic [1:0]       res_err,
   output logic             busy,
   output logic             done
);
   localparam int PC_W = $clog2(MAX_POLLS + 1);
   localparam int GC_W = $clog2(POLL_GAP + 1);
   localparam logic [31:0] RUN_MASK = 32'd1 << RUN_BIT;
   localparam logic [2:0] IDLE = 3'd0, WR_REF = 3'd1, WR_CTRL = 3'd2, GAP = 3'd3,
                          RD_STAT = 3'd4, STOP = 3'd5, PUSH = 3'd6, NEXT = 3'd7;

   logic [2:0]       state_q, state_d;
   logic             psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic             abort_q, abort_d, done_q, done_d;
   logic [4:0]       paddr_q, paddr_d;
   logic [31:0]      pwdata_q, pwdata_d, ref_q, ref_d, data_q, data_d;
   logic [SEL_W-1:0] idx_q, idx_d, last_q, last_d;
   logic [1:0]       err_q, err_d;
   logic [PC_W-1:0]  poll_q, poll_d, poll_inc;
   logic [GC_W-1:0]  gap_q, gap_d;
   logic             apb_st, access_done;
   logic [4:0]       tgt_addr;
   logic [31:0]      tgt_data;

   assign psel = psel_q;
   assign penable = penable_q;
   assign pwrite = pwrite_q;
   assign paddr = paddr_q;
   assign pwdata = pwdata_q;
   assign res_valid = state_q == PUSH;
   assign res_idx = idx_q;
   assign res_data = data_q;
   assign res_err = err_q;
   assign busy = state_q != IDLE;
   assign done = done_q;

   assign apb_st = (state_q == WR_REF) | (state_q == WR_CTRL) | (state_q == RD_STAT) | (state_q == STOP);
   assign tgt_addr = state_q == WR_REF ? ADDR_REF : state_q == RD_STAT ? ADDR_STAT : ADDR_CTRL;
   assign tgt_data = state_q == WR_REF ? ref_q : state_q == RD_STAT ? 32'd0 :
                     state_q == WR_CTRL ? (32'(idx_q) | RUN_MASK) : 32'(idx_q);
   assign access_done = psel_q & penable_q & pready;
   assign poll_inc = poll_q == PC_W'(MAX_POLLS) ? poll_q : poll_q + 1'b1;

   always_comb begin
      state_d = state_q;
      psel_d = psel_q;
      penable_d = penable_q;
      pwrite_d = pwrite_q;
      paddr_d = paddr_q;
      pwdata_d = pwdata_q;
      ref_d = ref_q;
      data_d = data_q;
      idx_d = idx_q;
      last_d = last_q;
      err_d = err_q;
      poll_d = poll_q;
      gap_d = gap_q;
      done_d = 1'b0;
      abort_d = (state_q != IDLE) & (abort_q | abort);
      // each APB state spends one idle cycle deciding, keeping psel low between transfers
      if (apb_st & !psel_q) begin
         if (abort_q & ((state_q == WR_REF) | (state_q == WR_CTRL))) state_d = NEXT;
         else if (abort_q & (state_q == RD_STAT)) begin
            err_d = 2'd1;
            state_d = STOP;
         end else begin
            psel_d = 1'b1;
            pwrite_d = state_q != RD_STAT;
            paddr_d = tgt_addr;
            pwdata_d = tgt_data;
         end
      end else if (apb_st & !penable_q) penable_d = 1'b1;
      if (access_done) begin
         psel_d = 1'b0;
         penable_d = 1'b0;
      end
      case (state_q)
         IDLE: if (start) begin
            if (first_idx <= last_idx) begin
               last_d = last_idx;
               ref_d = ref_window;
               idx_d = first_idx;
               err_d = 2'd0;
               data_d = 32'd0;
               state_d = WR_REF;
            end else done_d = 1'b1;
         end
         WR_REF: if (access_done) begin
            err_d = pslverr ? 2'd2 : err_q;
            state_d = pslverr ? PUSH : WR_CTRL;
         end
         WR_CTRL: if (access_done) begin
            err_d = pslverr ? 2'd2 : err_q;
            poll_d = '0;
            gap_d = '0;
            state_d = pslverr ? PUSH : GAP;
         end
         GAP: begin
            if (abort_q) begin
               err_d = 2'd1;
               state_d = STOP;
            end else if (gap_q == GC_W'(POLL_GAP - 1)) state_d = RD_STAT;
            else gap_d = gap_q + 1'b1;
         end
         RD_STAT: if (access_done) begin
            if (!pslverr) begin
               data_d = prdata;
               state_d = STOP;
            end else begin
               poll_d = poll_inc;
               gap_d = '0;
               err_d = poll_inc == PC_W'(MAX_POLLS) ? 2'd1 : err_q;
               state_d = poll_inc == PC_W'(MAX_POLLS) ? STOP : GAP;
            end
         end
         STOP: if (access_done) begin
            data_d = pslverr ? 32'd0 : data_q;
            err_d = (pslverr & (err_q == 2'd0)) ? 2'd2 : err_q;
            state_d = PUSH;
         end
         PUSH: state_d = res_ready ? NEXT : PUSH;
         NEXT: begin
            if ((idx_q == last_q) | abort_q) begin
               done_d = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
               err_d = 2'd0;
               data_d = 32'd0;
               state_d = WR_REF;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         psel_q <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q <= '0;
         pwdata_q <= '0;
         ref_q <= '0;
         data_q <= '0;
         idx_q <= '0;
         last_q <= '0;
         err_q <= '0;
         poll_q <= '0;
         gap_q <= '0;
         abort_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         psel_q <= psel_d;
         penable_q <= penable_d;
         pwrite_q <= pwrite_d;
         paddr_q <= paddr_d;
         pwdata_q <= pwdata_d;
         ref_q <= ref_d;
         data_q <= data_d;
         idx_q <= idx_d;
         last_q <= last_d;
         err_q <= err_d;
         poll_q <= poll_d;
         gap_q <= gap_d;
         abort_q <= abort_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_pm_sensor_sweep_ctrl.sv
// tb_pm_sensor_sweep_ctrl: APB slave model plus transaction-level reference for the sensor sweeper
module tb_pm_sensor_sweep_ctrl;
   localparam int MP = 4;
   localparam int PG = 3;

   logic pclk = 1'b0, preset = 1'b1, start = 1'b0, abort = 1'b0;
   logic [4:0] first_idx = '0, last_idx = '0;
   logic [31:0] ref_window = '0, prdata = '0, pwdata;
   logic pready = 1'b0, pslverr = 1'b0, res_ready = 1'b0;
   logic psel, penable, pwrite, res_valid, busy, done;
   logic [4:0] paddr, res_idx;
   logic [31:0] res_data;
   logic [1:0] res_err;

   pm_sensor_sweep_ctrl #(.SEL_W(5), .RUN_BIT(10), .POLL_GAP(PG), .MAX_POLLS(MP)) dut (
      .pclk(pclk), .preset(preset), .start(start), .abort(abort), .first_idx(first_idx),
      .last_idx(last_idx), .ref_window(ref_window), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
      .res_data(res_data), .res_err(res_err), .busy(busy), .done(done));

   always #5 pclk = ~pclk;

   typedef struct {bit w; logic [4:0] a; logic [31:0] d;} tr_t;
   typedef struct {logic [4:0] ix; logic [31:0] dat; logic [1:0] er;} res_t;
   tr_t act_tr[$], exp_tr[$];
   res_t act_res[$], exp_res[$];
   int n_cmp = 0, n_bad = 0;
   int polls_needed[32];
   logic [31:0] sdata[32];
   int ctrl_err_idx = -1, wait_states = 0, stall = 0, done_cnt = 0, last_run_idx = -1;
   int wcnt = 0, rd_cnt = 0, st = 0;
   logic [4:0] cur = '0, sa = '0;
   logic sw = 1'b0;
   logic [31:0] sd = '0;
   bit hold = 1'b0;
   res_t held;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Slave, result consumer and protocol monitors all act on the falling edge
   always @(negedge pclk) begin
      if (done) done_cnt++;
      if (res_valid) check("push_no_apb", 32'(psel), 32'd0);
      if (psel && !penable) begin
         sa = paddr; sw = pwrite; sd = pwdata;
         pready = 1'b0; pslverr = 1'b0; wcnt = 0;
      end else if (psel && penable) begin
         check("apb_hold_ctl", 32'({pwrite, paddr}), 32'({sw, sa}));
         check("apb_hold_wdata", pwdata, sd);
         if (wcnt < wait_states) begin
            pready = 1'b0; wcnt++;
         end else begin
            pready = 1'b1; pslverr = 1'b0; prdata = '0; wcnt = 0;
            if (!pwrite) begin
               if (rd_cnt < polls_needed[cur]) pslverr = 1'b1;
               else prdata = sdata[cur];
               rd_cnt++;
               act_tr.push_back('{w: 1'b0, a: paddr, d: 32'd0});
            end else begin
               if (paddr == 5'h04 && pwdata[10]) begin
                  cur = pwdata[4:0]; rd_cnt = 0; last_run_idx = int'(cur);
                  if (int'(cur) == ctrl_err_idx) pslverr = 1'b1;
               end
               act_tr.push_back('{w: 1'b1, a: paddr, d: pwdata});
            end
         end
      end else begin
         pready = 1'b0; pslverr = 1'b0;
      end
      if (res_valid) begin
         if (hold) begin
            check("res_hold_idx", 32'(res_idx), 32'(held.ix));
            check("res_hold_data", res_data, held.dat);
            check("res_hold_err", 32'(res_err), 32'(held.er));
         end
         if (st < stall) begin
            res_ready = 1'b0; st++; hold = 1'b1;
            held = '{ix: res_idx, dat: res_data, er: res_err};
         end else begin
            res_ready = 1'b1; st = 0; hold = 1'b0;
            act_res.push_back('{ix: res_idx, dat: res_data, er: res_err});
         end
      end else begin
         res_ready = 1'b0; hold = 1'b0;
      end
   end

   // Reference: the APB transactions and results a sweep must produce, independent of timing
   task automatic build_exp(input int first, input int last, input logic [31:0] refw, input int abort_at);
      for (int i = first; i <= last; i++) begin
         int n;
         bit to;
         exp_tr.push_back('{w: 1'b1, a: 5'h08, d: refw});
         exp_tr.push_back('{w: 1'b1, a: 5'h04, d: 32'h400 | 32'(i)});
         if (i == ctrl_err_idx) begin
            exp_res.push_back('{ix: 5'(i), dat: 32'd0, er: 2'd2});
            continue;
         end
         if (i == abort_at) begin
            exp_tr.push_back('{w: 1'b1, a: 5'h04, d: 32'(i)});
            exp_res.push_back('{ix: 5'(i), dat: 32'd0, er: 2'd1});
            break;
         end
         to = polls_needed[i] >= MP;
         n = to ? MP : polls_needed[i] + 1;
         repeat (n) exp_tr.push_back('{w: 1'b0, a: 5'h0C, d: 32'd0});
         exp_tr.push_back('{w: 1'b1, a: 5'h04, d: 32'(i)});
         exp_res.push_back('{ix: 5'(i), dat: to ? 32'd0 : sdata[i], er: to ? 2'd1 : 2'd0});
      end
   endtask

   task automatic compare_logs(input string tag);
      check({tag, "_ntr"}, 32'(act_tr.size()), 32'(exp_tr.size()));
      for (int i = 0; i < exp_tr.size() && i < act_tr.size(); i++) begin
         check($sformatf("%s_tr%0d_ctl", tag, i), 32'({act_tr[i].w, act_tr[i].a}), 32'({exp_tr[i].w, exp_tr[i].a}));
         check($sformatf("%s_tr%0d_data", tag, i), act_tr[i].d, exp_tr[i].d);
      end
      check({tag, "_nres"}, 32'(act_res.size()), 32'(exp_res.size()));
      for (int i = 0; i < exp_res.size() && i < act_res.size(); i++) begin
         check($sformatf("%s_res%0d_idx", tag, i), 32'(act_res[i].ix), 32'(exp_res[i].ix));
         check($sformatf("%s_res%0d_data", tag, i), act_res[i].dat, exp_res[i].dat);
         check($sformatf("%s_res%0d_err", tag, i), 32'(act_res[i].er), 32'(exp_res[i].er));
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_apbctl"}, 32'({psel, penable, pwrite}), 32'd0);
      check({tag, "_paddr"}, 32'(paddr), 32'd0);
      check({tag, "_pwdata"}, pwdata, 32'd0);
      check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_res_idx"}, 32'(res_idx), 32'd0);
      check({tag, "_res_data"}, res_data, 32'd0);
      check({tag, "_res_err"}, 32'(res_err), 32'd0);
      check({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
   endtask

   task automatic run_sweep(input int first, input int last, input logic [31:0] refw, input int abort_at,
                            input bit with_abort, input bit extra_start, input string tag);
      int d0;
      bit ok, fired;
      act_tr.delete(); act_res.delete(); exp_tr.delete(); exp_res.delete();
      last_run_idx = -1;
      build_exp(first, last, refw, abort_at);
      d0 = done_cnt; ok = 1'b0; fired = 1'b0;
      first_idx = 5'(first); last_idx = 5'(last); ref_window = refw;
      start = 1'b1; abort = with_abort;
      @(posedge pclk); #1;
      start = 1'b0; abort = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      for (int t = 0; t < 8000; t++) begin
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
         if (abort) abort = 1'b0;
         else if (abort_at >= 0 && !fired && last_run_idx == abort_at) begin
            abort = 1'b1; fired = 1'b1;
         end
         if (extra_start && t == 10 && busy) begin
            first_idx = 5'd0; last_idx = 5'd31; ref_window = ~refw; start = 1'b1;
            @(posedge pclk); #1;
            start = 1'b0;
         end
         @(posedge pclk); #1;
      end
      check({tag, "_done_seen"}, 32'(ok), 32'd1);
      repeat (3) @(posedge pclk);
      #1;
      check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      compare_logs(tag);
   endtask

   initial begin
      int f, l, n0;
      bit seen;
      for (int i = 0; i < 32; i++) begin
         polls_needed[i] = 0;
         sdata[i] = $urandom | 32'h1;
      end
      repeat (3) @(posedge pclk);
      #1;
      check_reset("rst0");
      preset = 1'b0;
      @(posedge pclk); #1;

      polls_needed[3] = 2;
      run_sweep(3, 3, 32'h100, -1, 1'b1, 1'b0, "single");
      if (act_tr.size() == 6) begin
         check("single_wr_ref", act_tr[0].d, 32'h100);
         check("single_wr_run", act_tr[1].d, 32'h403);
         check("single_wr_stop", act_tr[5].d, 32'h003);
      end

      stall = 5;
      for (int i = 0; i < 8; i++) polls_needed[i] = int'($urandom_range(0, 2));
      run_sweep(0, 7, 32'h2468, -1, 1'b0, 1'b0, "stall");
      stall = 0;

      polls_needed[5] = 100;
      run_sweep(5, 5, 32'h55, -1, 1'b0, 1'b0, "timeout");

      ctrl_err_idx = 1;
      run_sweep(0, 2, 32'h77, -1, 1'b0, 1'b0, "werr");
      ctrl_err_idx = -1;

      for (int i = 0; i < 6; i++) polls_needed[i] = 1;
      run_sweep(0, 5, 32'h99, 2, 1'b0, 1'b0, "abort");

      n0 = done_cnt;
      first_idx = 5'd6; last_idx = 5'd2; act_tr.delete(); start = 1'b1;
      @(posedge pclk); #1;
      start = 1'b0;
      check("empty_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge pclk);
      #1;
      check("empty_done", 32'(done_cnt - n0), 32'd1);
      check("empty_no_apb", 32'(act_tr.size()), 32'd0);

      for (int r = 0; r < 6; r++) begin
         f = int'($urandom_range(0, 27));
         l = f + int'($urandom_range(0, 3));
         for (int i = f; i <= l; i++) polls_needed[i] = int'($urandom_range(0, 5));
         wait_states = int'($urandom_range(0, 2));
         stall = int'($urandom_range(0, 3));
         ctrl_err_idx = $urandom_range(0, 1) ? f + int'($urandom_range(0, l - f)) : -1;
         run_sweep(f, l, $urandom, -1, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      end
      ctrl_err_idx = -1; stall = 0;

      wait_states = 3;
      polls_needed[4] = 1;
      act_tr.delete(); act_res.delete();
      first_idx = 5'd4; last_idx = 5'd4; ref_window = 32'hABC; start = 1'b1;
      @(posedge pclk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 500 && !seen; t++) begin
         if (psel && penable && paddr == 5'h0C) seen = 1'b1;
         else begin
            @(posedge pclk); #1;
         end
      end
      check("rstmid_in_rd", 32'(seen), 32'd1);
      check("rstmid_prior_wr", 32'(act_tr.size()), 32'd2);
      preset = 1'b1;
      @(posedge pclk); #1;
      check_reset("rstmid");
      preset = 1'b0;
      n0 = act_tr.size();
      repeat (20) @(posedge pclk);
      #1;
      check("rstmid_no_stop", 32'(act_tr.size()), 32'(n0));
      check("rstmid_idle", 32'({psel, busy, res_valid}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
